// File: rtl/fx_sched_pkg.sv
// Shared types and defaults for the stereo effect channel scheduler.
// The FSM state encoding lives here so the sub-module and the bench agree.
package fx_sched_pkg;

    localparam int FX_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEFT_REQ,
        LEFT_WAIT,
        RIGHT_REQ,
        RIGHT_WAIT,
        PUBLISH
    } state_t;

endpackage

// File: rtl/fx_channel_scheduler_watchdog.sv
// fx_watchdog: loadable down-counter whose expiry flag marks the last allowed
// wait cycle. It is only instantiated when FX_SCHED_TIMEOUT_EN is defined.
module fx_watchdog #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == W'(1));

endmodule

// File: rtl/fx_channel_scheduler.sv
// Time-shares one effect datapath between the left and right channel of each
// frame. Optional wait-state watchdog is enabled by FX_SCHED_TIMEOUT_EN.
module fx_channel_scheduler
    import fx_sched_pkg::*;
#(
    parameter int DATA_WIDTH = FX_DATA_WIDTH,
    parameter int TIMEOUT    = 15
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  audio_ready,
    input  logic [DATA_WIDTH-1:0] left_in,
    input  logic [DATA_WIDTH-1:0] right_in,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] fx_x,
    output logic                  fx_start,
    input  logic                  fx_done,
    input  logic [DATA_WIDTH-1:0] fx_y,
    output logic [DATA_WIDTH-1:0] left_out,
    output logic [DATA_WIDTH-1:0] right_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout_err,
    input  logic                  flags_clr
);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_left;
    logic [DATA_WIDTH-1:0] r_right;
    logic [DATA_WIDTH-1:0] r_lres;
    logic [DATA_WIDTH-1:0] r_fx_x;
    logic [DATA_WIDTH-1:0] r_left_out;
    logic [DATA_WIDTH-1:0] r_right_out;
    logic                  r_en;
    logic                  r_fx_start;
    logic                  r_out_valid;
    logic                  r_overrun;
    logic                  w_busy;
    logic                  w_tmo;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    assign w_busy = (r_state != IDLE);

`ifdef FX_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic w_wait;
    logic w_load;
    logic w_expired;
    logic r_tmo_err;

    assign w_wait = (r_state == LEFT_WAIT) || (r_state == RIGHT_WAIT);
    assign w_load = (r_state == LEFT_REQ) || (r_state == RIGHT_REQ);
    assign w_tmo  = w_wait && w_expired && !fx_done;

    fx_watchdog #(
        .W(TW)
    ) u_wdog (
        .i_clk     (CLK),
        .i_rst     (rst),
        .i_load    (w_load),
        .i_load_val(TW'(TIMEOUT)),
        .i_dec     (w_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_tmo_err <= 1'b0;
        end else if (w_tmo) begin
            r_tmo_err <= 1'b1;
        end else if (flags_clr) begin
            r_tmo_err <= 1'b0;
        end
    end

    assign timeout_err = r_tmo_err;
`else
    assign w_tmo       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state     <= IDLE;
            r_left      <= '0;
            r_right     <= '0;
            r_lres      <= '0;
            r_fx_x      <= '0;
            r_left_out  <= '0;
            r_right_out <= '0;
            r_en        <= 1'b0;
            r_fx_start  <= 1'b0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_fx_start  <= 1'b0;
            r_out_valid <= 1'b0;

            if (audio_ready && w_busy) begin
                r_overrun <= 1'b1;
            end else if (flags_clr) begin
                r_overrun <= 1'b0;
            end

            unique case (r_state)
                IDLE: begin
                    if (audio_ready) begin
                        r_left  <= left_in;
                        r_right <= right_in;
                        r_en    <= en;
                        r_state <= en ? LEFT_REQ : PUBLISH;
                    end
                end
                LEFT_REQ: begin
                    r_fx_x     <= r_left;
                    r_fx_start <= 1'b1;
                    r_state    <= LEFT_WAIT;
                end
                LEFT_WAIT: begin
                    if (fx_done) begin
                        r_lres  <= fx_y;
                        r_state <= RIGHT_REQ;
                    end else if (w_tmo) begin
                        r_lres  <= r_left;
                        r_state <= RIGHT_REQ;
                    end
                end
                RIGHT_REQ: begin
                    r_fx_x     <= r_right;
                    r_fx_start <= 1'b1;
                    r_state    <= RIGHT_WAIT;
                end
                // Effect frames publish on the completion edge so out_valid
                // is high while the FSM sits in PUBLISH.
                RIGHT_WAIT: begin
                    if (fx_done || w_tmo) begin
                        r_left_out  <= r_lres;
                        r_right_out <= fx_done ? fx_y : r_right;
                        r_out_valid <= 1'b1;
                        r_state     <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    if (!r_en) begin
                        r_left_out  <= r_left;
                        r_right_out <= r_right;
                        r_out_valid <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fx_x      = r_fx_x;
    assign fx_start  = r_fx_start;
    assign left_out  = r_left_out;
    assign right_out = r_right_out;
    assign out_valid = r_out_valid;
    assign busy      = w_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_fx_channel_scheduler.sv
// Directed bench for fx_channel_scheduler with an effect model returning x<<1.
// Define FX_SCHED_TIMEOUT_EN to also exercise the watchdog path.
module tb_fx_channel_scheduler;

    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          rst;
    logic          audio_ready;
    logic          en;
    logic          flags_clr;
    logic [DW-1:0] left_in;
    logic [DW-1:0] right_in;
    logic [DW-1:0] fx_x;
    logic          fx_start;
    logic          fx_done;
    logic [DW-1:0] fx_y;
    logic [DW-1:0] left_out;
    logic [DW-1:0] right_out;
    logic          out_valid;
    logic          busy;
    logic          overrun;
    logic          timeout_err;

    int n_vec = 0;
    int n_err = 0;

    int            cyc = 0;
    int            n_start = 0;
    int            n_valid = 0;
    int            v_cyc = 0;
    int            done_cyc = 0;
    int            start_cyc = 0;
    int            prev_start_cyc = 0;
    logic [DW-1:0] v_l = '0;
    logic [DW-1:0] v_r = '0;

    int lat = 2;
    bit resp_en = 1'b1;
    int skip_n = -1;

    fx_channel_scheduler #(
        .DATA_WIDTH(DW),
        .TIMEOUT   (15)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .audio_ready(audio_ready),
        .left_in    (left_in),
        .right_in   (right_in),
        .en         (en),
        .fx_x       (fx_x),
        .fx_start   (fx_start),
        .fx_done    (fx_done),
        .fx_y       (fx_y),
        .left_out   (left_out),
        .right_out  (right_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .overrun    (overrun),
        .timeout_err(timeout_err),
        .flags_clr  (flags_clr)
    );

    always #5 CLK = ~CLK;

    // Effect model: answers x<<1 with fx_done 'lat' cycles after fx_start.
    initial begin : responder
        int            seen;
        logic [DW-1:0] x;
        seen    = 0;
        fx_done = 1'b0;
        fx_y    = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (fx_start) begin
                x = fx_x;
                if (resp_en && (seen != skip_n)) begin
                    seen = seen + 1;
                    repeat (lat) @(posedge CLK);
                    #1;
                    fx_done = 1'b1;
                    fx_y    = x << 1;
                    @(posedge CLK);
                    #1;
                    fx_done = 1'b0;
                end else begin
                    seen = seen + 1;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(posedge CLK);
            #2;
            cyc = cyc + 1;
            if (fx_start) begin
                prev_start_cyc = start_cyc;
                start_cyc      = cyc;
                n_start        = n_start + 1;
            end
            if (fx_done) done_cyc = cyc;
            if (out_valid) begin
                n_valid = n_valid + 1;
                v_cyc   = cyc;
                v_l     = left_out;
                v_r     = right_out;
            end
        end
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #3;
    endtask

    task automatic send(input logic e, input logic [DW-1:0] l,
                        input logic [DW-1:0] r, output int a);
        audio_ready = 1'b1;
        en          = e;
        left_in     = l;
        right_in    = r;
        a           = cyc;
        tick();
        audio_ready = 1'b0;
    endtask

    task automatic wait_valid(input int nv0, input int budget,
                              input string tag);
        int k;
        k = 0;
        while ((n_valid == nv0) && (k < budget)) begin
            tick();
            k = k + 1;
        end
        chk(tag, 64'(n_valid - nv0), 64'd1);
    endtask

    initial begin : main
        int a;
        int b;
        int k;
        int nv0;
        int ns0;

        rst         = 1'b1;
        audio_ready = 1'b0;
        en          = 1'b0;
        flags_clr   = 1'b0;
        left_in     = '0;
        right_in    = '0;
        repeat (3) tick();

        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fx_start", 64'(fx_start), 64'd0);
        chk("rst_fx_x", 64'(fx_x), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_left_out", 64'(left_out), 64'd0);
        chk("rst_right_out", 64'(right_out), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_timeout_err", 64'(timeout_err), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Effect frame
        nv0 = n_valid;
        ns0 = n_start;
        lat = 2;
        send(1'b1, 32'h0000_0100, 32'h0000_0200, a);
        wait_valid(nv0, 40, "fx_valid_seen");
        chk("fx_strobe_left", 64'(v_l), 64'h200);
        chk("fx_strobe_right", 64'(v_r), 64'h400);
        chk("fx_latency", 64'(v_cyc - done_cyc), 64'd1);
        repeat (3) tick();
        chk("fx_left_out", 64'(left_out), 64'h200);
        chk("fx_right_out", 64'(right_out), 64'h400);
        chk("fx_starts", 64'(n_start - ns0), 64'd2);
        chk("fx_valid_once", 64'(n_valid - nv0), 64'd1);
        chk("fx_idle", 64'(busy), 64'd0);

        // Bypass frame
        nv0 = n_valid;
        ns0 = n_start;
        send(1'b0, 32'hAAAA_0000, 32'h5555_FFFF, a);
        wait_valid(nv0, 10, "byp_valid_seen");
        chk("byp_latency", 64'(v_cyc - a), 64'd2);
        chk("byp_left", 64'(v_l), 64'hAAAA_0000);
        chk("byp_right", 64'(v_r), 64'h5555_FFFF);
        chk("byp_no_start", 64'(n_start - ns0), 64'd0);
        repeat (5) tick();
        chk("hold_left", 64'(left_out), 64'hAAAA_0000);
        chk("hold_right", 64'(right_out), 64'h5555_FFFF);
        chk("hold_no_valid", 64'(n_valid - nv0), 64'd1);

        // Overrun: stalled effect, second frame three cycles later
        nv0 = n_valid;
        lat = 6;
        send(1'b1, 32'h0000_0011, 32'h0000_0022, a);
        tick();
        tick();
        send(1'b1, 32'h0000_DEAD, 32'h0000_BEEF, b);
        chk("ovr_set", 64'(overrun), 64'd1);
        audio_ready = 1'b1;
        flags_clr   = 1'b1;
        tick();
        audio_ready = 1'b0;
        flags_clr   = 1'b0;
        chk("ovr_set_wins", 64'(overrun), 64'd1);
        wait_valid(nv0, 40, "ovr_valid_seen");
        chk("ovr_left", 64'(v_l), 64'h22);
        chk("ovr_right", 64'(v_r), 64'h44);
        repeat (12) tick();
        chk("ovr_dropped", 64'(n_valid - nv0), 64'd1);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("ovr_clr", 64'(overrun), 64'd0);

        // Reset in LEFT_WAIT, then a late fx_done
        nv0 = n_valid;
        lat = 2;
        send(1'b1, 32'h0000_0040, 32'h0000_0050, a);
        tick();
        chk("rw_start", 64'(fx_start), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_busy", 64'(busy), 64'd0);
        chk("rw_left_out", 64'(left_out), 64'd0);
        chk("rw_right_out", 64'(right_out), 64'd0);
        chk("rw_fx_x", 64'(fx_x), 64'd0);
        chk("rw_late_done", 64'(fx_done), 64'd1);
        repeat (6) tick();
        chk("rw_no_valid", 64'(n_valid - nv0), 64'd0);
        chk("rw_still_idle", 64'(busy), 64'd0);
        nv0 = n_valid;
        send(1'b1, 32'h0000_0005, 32'h0000_0007, a);
        wait_valid(nv0, 40, "rw_next_seen");
        chk("rw_next_left", 64'(v_l), 64'h0A);
        chk("rw_next_right", 64'(v_r), 64'h0E);

        // en dropped during RIGHT_WAIT, then a bypassed frame
        repeat (2) tick();
        nv0 = n_valid;
        ns0 = n_start;
        lat = 3;
        send(1'b1, 32'h0000_0030, 32'h0000_0040, a);
        k = 0;
        while ((n_start - ns0 < 2) && (k < 30)) begin
            tick();
            k = k + 1;
        end
        chk("tog_right_start", 64'(n_start - ns0), 64'd2);
        en = 1'b0;
        wait_valid(nv0, 30, "tog_valid_seen");
        chk("tog_left", 64'(v_l), 64'h60);
        chk("tog_right", 64'(v_r), 64'h80);
        repeat (2) tick();
        nv0 = n_valid;
        ns0 = n_start;
        send(1'b0, 32'h0000_0030, 32'h0000_0040, a);
        wait_valid(nv0, 10, "tog_byp_seen");
        chk("tog_byp_left", 64'(v_l), 64'h30);
        chk("tog_byp_right", 64'(v_r), 64'h40);
        chk("tog_byp_no_start", 64'(n_start - ns0), 64'd0);
        repeat (2) tick();

`ifdef FX_SCHED_TIMEOUT_EN
        // Left request never answered: dry left, wet right, sticky error
        nv0    = n_valid;
        lat    = 2;
        skip_n = n_start;
        send(1'b1, 32'h0000_0100, 32'h0000_0200, a);
        wait_valid(nv0, 60, "tmo_valid_seen");
        chk("tmo_left", 64'(v_l), 64'h100);
        chk("tmo_right", 64'(v_r), 64'h400);
        chk("tmo_gap", 64'(start_cyc - prev_start_cyc), 64'd16);
        tick();
        chk("tmo_flag", 64'(timeout_err), 64'd1);
        skip_n    = -1;
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("tmo_clr", 64'(timeout_err), 64'd0);
`else
        chk("tmo_tied_low", 64'(timeout_err), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
